// File: rtl/uart_pkg.sv
// Shared UART types, constants and bit-level helpers used by the receiver and transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } uart_rx_state_e;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } uart_parity_e;

  // Expected parity bit for a frame payload (zero-extension leaves the XOR unchanged).
  function automatic logic parity_bit(input logic [31:0] data, input uart_parity_e mode);
    return (^data) ^ logic'(mode);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: down-counter reloading baud_div, tick while the count is zero.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             restart,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;

  // Divisor counter; restart realigns the tick phase to a detected start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (restart) begin
      cnt_r <= baud_div;
    end else if (cnt_r == {DIV_W{1'b0}}) begin
      cnt_r <= baud_div;
    end else begin
      cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick = (cnt_r == {DIV_W{1'b0}});

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled deserializer with a one-entry valid/ready holding register.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              rx_en,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_error,
  output logic              framing_error,
  output logic              overrun,
  output logic              busy,
  output logic              free
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [OS_W-1:0] VOTE_A = OS_W'(OVERSAMPLE/2 - 2);
  localparam logic [OS_W-1:0] VOTE_B = OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [OS_W-1:0] DECIDE = OS_W'(OVERSAMPLE/2);
`else
  localparam logic [OS_W-1:0] DECIDE = OS_W'(OVERSAMPLE/2 - 1);
`endif

  uart_rx_state_e    state_r, state_s;
  logic              sync1_r, sync2_r, prev_r;
  logic [OS_W-1:0]   os_cnt_r;
  logic [BC_W-1:0]   bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic              par_err_r, frm_err_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r, parity_error_r, framing_error_r, overrun_r;
  logic              tick_s, restart_s, complete_s, fall_s, sample_s, end_s, bit_s;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_div (baud_div),
    .restart  (restart_s),
    .tick     (tick_s)
  );

  // Line synchronizer plus previous-value flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx_i;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign fall_s   = prev_r & ~sync2_r;
  assign sample_s = tick_s & (state_r != IDLE) & (os_cnt_r == DECIDE);
  assign end_s    = tick_s & (os_cnt_r == OS_LAST);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_r;

  // Capture the two early votes; the third is the live line at the decision tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_r <= 2'b11;
    end else begin
      if (tick_s && os_cnt_r == VOTE_A) vote_r[1] <= sync2_r;
      if (tick_s && os_cnt_r == VOTE_B) vote_r[0] <= sync2_r;
    end
  end

  assign bit_s = majority3(vote_r[1], vote_r[0], sync2_r);
`else
  assign bit_s = sync2_r;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // States span whole bit periods; bits are sampled mid-period, completion at the final stop sample.
  always_comb begin
    state_s    = state_r;
    restart_s  = 1'b0;
    complete_s = 1'b0;
    if (!rx_en) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_s   = START;
            restart_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          if (sample_s && bit_s) state_s = IDLE;
          else if (end_s)        state_s = DATA;
          else                   state_s = START;
        end
        DATA: begin
          if (end_s && bit_cnt_r == BIT_LAST) state_s = parity_en ? PARITY : STOP;
          else                                state_s = DATA;
        end
        PARITY: begin
          if (end_s) state_s = STOP;
          else       state_s = PARITY;
        end
        STOP: begin
          if (sample_s && !stop2) begin
            complete_s = 1'b1;
            state_s    = IDLE;
          end else if (end_s && stop2) begin
            state_s = STOP2;
          end else begin
            state_s = STOP;
          end
        end
        STOP2: begin
          if (sample_s) begin
            complete_s = 1'b1;
            state_s    = IDLE;
          end else begin
            state_s = STOP2;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Oversample/bit counters, shift register and per-frame error accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt_r  <= {OS_W{1'b0}};
      bit_cnt_r <= {BC_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
    end else begin
      if (restart_s) begin
        os_cnt_r  <= {OS_W{1'b0}};
        bit_cnt_r <= {BC_W{1'b0}};
        par_err_r <= 1'b0;
        frm_err_r <= 1'b0;
      end else if (tick_s && state_r != IDLE) begin
        os_cnt_r <= (os_cnt_r == OS_LAST) ? {OS_W{1'b0}} : os_cnt_r + {{(OS_W-1){1'b0}}, 1'b1};
      end
      if (sample_s && state_r == DATA) shift_r <= {bit_s, shift_r[DATA_W-1:1]};
      if (end_s && state_r == DATA) bit_cnt_r <= bit_cnt_r + {{(BC_W-1){1'b0}}, 1'b1};
      if (sample_s && state_r == PARITY)
        par_err_r <= bit_s ^ parity_bit(32'(shift_r), uart_parity_e'(parity_odd));
      if (sample_s && state_r == STOP && !bit_s) frm_err_r <= 1'b1;
    end
  end

  // Holding register and completion pulses; a full, unaccepted register drops the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r       <= {DATA_W{1'b0}};
      rx_valid_r      <= 1'b0;
      parity_error_r  <= 1'b0;
      framing_error_r <= 1'b0;
      overrun_r       <= 1'b0;
    end else begin
      parity_error_r  <= complete_s & par_err_r;
      framing_error_r <= complete_s & (frm_err_r | ~bit_s);
      overrun_r       <= complete_s & rx_valid_r & ~rx_ready;
      if (complete_s && (!rx_valid_r || rx_ready)) begin
        rx_data_r  <= shift_r;
        rx_valid_r <= 1'b1;
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  assign rx_data       = rx_data_r;
  assign rx_valid      = rx_valid_r;
  assign parity_error  = parity_error_r;
  assign framing_error = framing_error_r;
  assign overrun       = overrun_r;
  assign busy          = (state_r != IDLE);
  assign free          = (state_r == IDLE) & ~rx_valid_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at baud_div=3 (64 clk per bit).
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n, rx_i, rx_en, parity_en, parity_odd, stop2, rx_ready;
  logic [15:0] baud_div;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_error, framing_error, overrun, busy, free;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0, pe_cnt = 0, fe_cnt = 0, ov_cnt = 0, busy_cnt = 0;
  logic [7:0] last_acc = 8'h00;
  int a0, p0, f0, o0, b0;

  uart_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_i          (rx_i),
    .baud_div      (baud_div),
    .rx_en         (rx_en),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .stop2         (stop2),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy),
    .free          (free)
  );

  always #5 clk = ~clk;

  // Event monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      acc_cnt  = acc_cnt + 1;
      last_acc = rx_data;
    end
    if (parity_error)  pe_cnt   = pe_cnt + 1;
    if (framing_error) fe_cnt   = fe_cnt + 1;
    if (overrun)       ov_cnt   = ov_cnt + 1;
    if (busy)          busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    a0 = acc_cnt; p0 = pe_cnt; f0 = fe_cnt; o0 = ov_cnt; b0 = busy_cnt;
  endtask

  task automatic bit_time(input logic v);
    rx_i = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_v,
                            input logic stop_a, input logic has_stop2, input logic stop_b);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (has_par) bit_time(par_v);
    bit_time(stop_a);
    if (has_stop2) bit_time(stop_b);
    rx_i = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 rx_ready = v;
  endtask

  initial begin
    rst_n = 1'b0; rx_i = 1'b1; rx_en = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    stop2 = 1'b0; rx_ready = 1'b1; baud_div = 16'd3;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_free", free, 1'b1);
    chk("rst_pulses", {parity_error, framing_error, overrun}, 3'b000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 basic frame
    snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("a5_acc", acc_cnt - a0, 1);
    chk("a5_data", last_acc, 8'hA5);
    chk("a5_err", (pe_cnt - p0) + (fe_cnt - f0) + (ov_cnt - o0), 0);
    chk("a5_busy_len", ((busy_cnt - b0) >= 600 && (busy_cnt - b0) <= 620), 1'b1);
    chk("a5_idle", {busy, free}, 2'b01);

    // even parity, wrong parity bit
    parity_en = 1'b1;
    snap();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("par07_bad_pe", pe_cnt - p0, 1);
    chk("par07_bad_data", last_acc, 8'h07);
    chk("par07_bad_acc", acc_cnt - a0, 1);
    snap();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("par07_ok_pe", pe_cnt - p0, 0);
    chk("par07_ok_acc", acc_cnt - a0, 1);
    // odd parity
    parity_odd = 1'b1;
    snap();
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("odd03_ok_pe", pe_cnt - p0, 0);
    snap();
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("odd03_bad_pe", pe_cnt - p0, 1);
    chk("odd03_data", last_acc, 8'h03);
    parity_en = 1'b0; parity_odd = 1'b0;

    // framing: low stop bit, then two-stop variants
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fe3c_fe", fe_cnt - f0, 1);
    chk("fe3c_data", last_acc, 8'h3C);
    chk("fe3c_busy", busy, 1'b0);
    stop2 = 1'b1;
    snap();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("s2_81_fe", fe_cnt - f0, 1);
    chk("s2_81_data", last_acc, 8'h81);
    snap();
    send_frame(8'hE7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("s2_e7_fe", fe_cnt - f0, 0);
    chk("s2_e7_data", last_acc, 8'hE7);
    stop2 = 1'b0;

    // glitch shorter than half a bit
    snap();
    rx_i = 1'b0;
    repeat (20) @(negedge clk);
    rx_i = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_acc", acc_cnt - a0, 0);
    chk("glitch_idle", {busy, free}, 2'b01);

    // rx_en dropped mid-frame
    snap();
    rx_i = 1'b0;
    repeat (192) @(negedge clk);
    chk("abort_busy_pre", busy, 1'b1);
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    rx_i = 1'b1;
    repeat (700) @(negedge clk);
    chk("abort_no_out", (acc_cnt - a0) + (pe_cnt - p0) + (fe_cnt - f0), 0);
    rx_en = 1'b1;
    repeat (4) @(negedge clk);

    // overrun with consumer stalled
    snap();
    set_ready(1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ov_first_valid", rx_valid, 1'b1);
    chk("ov_first_data", rx_data, 8'h11);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ov_keep_data", rx_data, 8'h11);
    chk("ov_pulse", ov_cnt - o0, 1);
    chk("ov_free", free, 1'b0);
    set_ready(1'b1);
    repeat (2) @(negedge clk);
    chk("ov_drain_valid", rx_valid, 1'b0);
    chk("ov_drain_data", last_acc, 8'h11);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ov_next_data", last_acc, 8'h33);
    chk("ov_once", ov_cnt - o0, 1);

    // reset mid-DATA of 0x5A, then a clean 0xC3
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    rx_i = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", rx_data, 8'h00);
    chk("rst_mid_state", {rx_valid, busy, free}, 3'b001);
    rx_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_pulses", {parity_error, framing_error, overrun}, 3'b000);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    snap();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("c3_acc", acc_cnt - a0, 1);
    chk("c3_data", last_acc, 8'hC3);
    chk("c3_err", (pe_cnt - p0) + (fe_cnt - f0) + (ov_cnt - o0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
